// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cond_pkg
// Brief    : Condition codes, flag bit positions and FlagW bit positions.
// Revision : 1.0 - initial release
// ============================================================================
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'd0,
        NE = 4'd1,
        CS = 4'd2,
        CC = 4'd3,
        MI = 4'd4,
        PL = 4'd5,
        VS = 4'd6,
        VC = 4'd7,
        HI = 4'd8,
        LS = 4'd9,
        GE = 4'd10,
        LT = 4'd11,
        GT = 4'd12,
        LE = 4'd13,
        AL = 4'd14,
        NV = 4'd15
    } cond_t;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    // FlagW bit that enables each flag pair
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage : cond_pkg
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
// Module   : cond_check
// Brief    : Combinational evaluation of a condition field against {N,Z,C,V}.
// Revision : 1.0 - initial release
// ============================================================================
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;
    logic ge;

    assign n_flag = Flags[N_IDX];
    assign z_flag = Flags[Z_IDX];
    assign c_flag = Flags[C_IDX];
    assign v_flag = Flags[V_IDX];
    assign ge     = (n_flag == v_flag);

    always_comb begin
        CondEx = 1'b0;
        case (cond_t'(Cond))
            EQ:      CondEx = z_flag;
            NE:      CondEx = ~z_flag;
            CS:      CondEx = c_flag;
            CC:      CondEx = ~c_flag;
            MI:      CondEx = n_flag;
            PL:      CondEx = ~n_flag;
            VS:      CondEx = v_flag;
            VC:      CondEx = ~v_flag;
            HI:      CondEx = c_flag & ~z_flag;
            LS:      CondEx = ~c_flag | z_flag;
            GE:      CondEx = ge;
            LT:      CondEx = ~ge;
            GT:      CondEx = ~z_flag & ge;
            LE:      CondEx = z_flag | ~ge;
            AL:      CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule : cond_check
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_unit
// Brief    : Execute-stage conditional logic: flag register and gated
//            Memory-stage control outputs.
// Revision : 1.0 - initial release
// ============================================================================
module cond_unit
    import cond_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic       Stall,
    input  logic       Flush,
    output logic       CondExE,
    output logic       PCSrcM,
    output logic       RegWriteM,
    output logic       MemWriteM,
    output logic [3:0] Flags
);

    logic cond_ex;
    logic write_nz;
    logic write_cv;

    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (Flags),
        .CondEx (CondExE)
    );

    // A stalled or flushed instruction must have no architectural effect
    assign cond_ex  = CondExE & ~Flush & ~Stall;
    assign write_nz = FlagW[FLAGW_NZ] & cond_ex;
    assign write_cv = FlagW[FLAGW_CV] & cond_ex;

    always_ff @(posedge clk) begin
        if (reset) begin
            Flags     <= 4'b0000;
            PCSrcM    <= 1'b0;
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
        end else begin
            if (write_nz) begin
                Flags[N_IDX] <= ALUFlags[N_IDX];
                Flags[Z_IDX] <= ALUFlags[Z_IDX];
            end
            if (write_cv) begin
                Flags[C_IDX] <= ALUFlags[C_IDX];
                Flags[V_IDX] <= ALUFlags[V_IDX];
            end
            if (!Stall) begin
                PCSrcM    <= PCS & cond_ex;
                RegWriteM <= RegW & cond_ex & ~NoWrite;
                MemWriteM <= MemW & cond_ex;
            end
        end
    end

endmodule : cond_unit
`default_nettype wire
